// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block: data width, settle
// counter width and the arbiter FSM state encoding.
package adder_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/adder_arbiter_adder.sv
// 16-bit ripple-carry adder: purely combinational. The sum is
// s_o = a_i + b_i + cin_i modulo 2^16, and the carry out of bit 15 is cout_o.
module adder_arbiter_adder
  import adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] s_o,
  output logic              cout_o
);

  logic [DATA_W:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one ripple adder, served round-robin.
// An operation is accepted in IDLE. The adder is then given SETTLE_CYCLES
// cycles to settle, the result is captured, and it is presented in RESP until
// it is accepted.
// Optional feature: define ADDER_ARBITER_OVF_EN to add the rsp_ovf output,
// which flags signed (two's-complement) overflow.
//
// Handshake: a transfer happens only on a rising Clk edge where valid and
// ready are both high. reqN_ready is combinational: it is high only in IDLE,
// only for the requester that wins arbitration, and only while that
// requester's valid is high. While rsp_valid is high, rsp_S, rsp_cout and
// rsp_id (and rsp_ovf, when present) hold their values until rsp_ready is high.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic              req1_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_S,
  output logic              rsp_cout,
  output logic              rsp_id,
`ifdef ADDER_ARBITER_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic              ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cap_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              cin_q, id_q;
  logic [DATA_W-1:0] rsp_s_q;
  logic              rsp_cout_q, rsp_id_q;
  logic [DATA_W-1:0] sum;
  logic              sum_cout;
  logic              gnt0, gnt1, grant, capture;

  // Round-robin choice. A lone valid always wins; the pointer only breaks ties.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~ptr_q);
    gnt1 = req1_valid & (~req0_valid |  ptr_q);
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state. RESP is entered one cycle after the sum is captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0 && cap_q) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. The ready outputs are forced low while reset is asserted.
  always_comb begin
    req0_ready = Reset_n & (state_q == ST_IDLE) & gnt0;
    req1_ready = Reset_n & (state_q == ST_IDLE) & gnt1;
    grant      = req0_ready | req1_ready;
    rsp_valid  = (state_q == ST_RESP);
    capture    = (state_q == ST_SETTLE) & (cnt_q == '0) & ~cap_q;
  end

  // Arbitration pointer, settle countdown and the captured-result flag.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_q <= 1'b0;
      cnt_q <= '0;
      cap_q <= 1'b0;
    end else if (grant) begin
      ptr_q <= gnt0;
      cnt_q <= CNT_LOAD;
      cap_q <= 1'b0;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else             cap_q <= 1'b1;
    end
  end

  // Operand registers feeding the shared adder, loaded from the winner.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      id_q  <= 1'b0;
    end else if (grant) begin
      a_q   <= gnt1 ? req1_A   : req0_A;
      b_q   <= gnt1 ? req1_B   : req0_B;
      cin_q <= gnt1 ? req1_cin : req0_cin;
      id_q  <= gnt1;
    end
  end

  adder_arbiter_adder u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .s_o    (sum),
    .cout_o (sum_cout)
  );

  // Response registers, captured once the adder has settled.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else if (capture) begin
      rsp_s_q    <= sum;
      rsp_cout_q <= sum_cout;
      rsp_id_q   <= id_q;
    end
  end

`ifdef ADDER_ARBITER_OVF_EN
  logic rsp_ovf_q;

  // Signed overflow: the operands have the same sign and the sum's sign differs.
  always_ff @(posedge Clk) begin
    if (!Reset_n)     rsp_ovf_q <= 1'b0;
    else if (capture) rsp_ovf_q <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                                   (sum[DATA_W-1] != a_q[DATA_W-1]);
  end

  assign rsp_ovf = rsp_ovf_q;
`endif

  assign rsp_S     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter. The instance dut uses the default
// SETTLE_CYCLES of 1, and dut4 uses SETTLE_CYCLES = 4.
// Compile with ADDER_ARBITER_OVF_EN defined to also cover rsp_ovf.
module tb_adder_arbiter;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic        Reset_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_A, req0_B;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_A, req1_B;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [15:0] rsp_S;
  logic [1:0]  dbg_state;
`ifdef ADDER_ARBITER_OVF_EN
  logic        rsp_ovf;
`endif

  logic        s4_req0_valid, s4_req0_ready, s4_req0_cin;
  logic [15:0] s4_req0_A, s4_req0_B;
  logic        s4_req1_valid, s4_req1_ready, s4_req1_cin;
  logic [15:0] s4_req1_A, s4_req1_B;
  logic        s4_rsp_valid, s4_rsp_ready, s4_rsp_cout, s4_rsp_id;
  logic [15:0] s4_rsp_S;
  logic [1:0]  s4_dbg_state;
`ifdef ADDER_ARBITER_OVF_EN
  logic        s4_rsp_ovf;
`endif

  adder_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_S(rsp_S), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
`ifdef ADDER_ARBITER_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .dbg_state(dbg_state)
  );

  adder_arbiter #(.SETTLE_CYCLES(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0_valid(s4_req0_valid), .req0_ready(s4_req0_ready),
    .req0_A(s4_req0_A), .req0_B(s4_req0_B), .req0_cin(s4_req0_cin),
    .req1_valid(s4_req1_valid), .req1_ready(s4_req1_ready),
    .req1_A(s4_req1_A), .req1_B(s4_req1_B), .req1_cin(s4_req1_cin),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready),
    .rsp_S(s4_rsp_S), .rsp_cout(s4_rsp_cout), .rsp_id(s4_rsp_id),
`ifdef ADDER_ARBITER_OVF_EN
    .rsp_ovf(s4_rsp_ovf),
`endif
    .dbg_state(s4_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  int          grant_cyc;
  int          lat;
  logic [15:0] got_s;
  logic        got_cout, got_id;

  // Present one request, wait for its grant, then withdraw valid.
  task automatic send_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    bit seen = 1'b0;
    @(negedge Clk);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_A = a; req0_B = b; req0_cin = cin;
    end else begin
      req1_valid = 1'b1; req1_A = a; req1_B = b; req1_cin = cin;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check("grant_seen", 32'(seen), 32'd1);
    grant_cyc = cyc + 1;
    @(posedge Clk);
    @(negedge Clk);
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Wait for rsp_valid, then record its latency from the grant edge and its data.
  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check("rsp_seen", 32'(seen), 32'd1);
    lat      = cyc - grant_cyc;
    got_s    = rsp_S;
    got_cout = rsp_cout;
    got_id   = rsp_id;
  endtask

  task automatic do_op(input string tag, input bit id, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic [15:0] exp_s, input logic exp_cout);
    send_req(id, a, b, cin);
    wait_rsp();
    check({tag, "_lat"},  32'(lat),      32'd2);
    check({tag, "_S"},    32'(got_s),    32'(exp_s));
    check({tag, "_cout"}, 32'(got_cout), 32'(exp_cout));
    check({tag, "_id"},   32'(got_id),   32'(id));
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int n_rsp;
  int n_bad;

  initial begin
    Reset_n    = 1'b0;
    req0_valid = 1'b1; req0_A = '0; req0_B = '0; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_A = '0; req1_B = '0; req1_cin = 1'b0;
    rsp_ready  = 1'b1;
    s4_req0_valid = 1'b0; s4_req0_A = '0; s4_req0_B = '0; s4_req0_cin = 1'b0;
    s4_req1_valid = 1'b0; s4_req1_A = '0; s4_req1_B = '0; s4_req1_cin = 1'b0;
    s4_rsp_ready  = 1'b1;

    // Reset state, with both valids high so the ready gating is exercised.
    repeat (3) @(negedge Clk);
    #1;
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_S",      32'(rsp_S),      32'd0);
    check("rst_rsp_cout",   32'(rsp_cout),   32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_state",      32'(dbg_state),  32'd0);
`ifdef ADDER_ARBITER_OVF_EN
    check("rst_ovf",        32'(rsp_ovf),    32'd0);
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    Reset_n    = 1'b1;

    // Basic operation and boundary sums.
    do_op("add_1_2", 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
`ifdef ADDER_ARBITER_OVF_EN
    check("add_1_2_ovf", 32'(rsp_ovf), 32'd0);
`endif
    @(negedge Clk);
    check("rsp_consumed", 32'(rsp_valid), 32'd0);
    do_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("add_cin",    1'b1, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0);
    do_op("add_8000",   1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    do_op("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef ADDER_ARBITER_OVF_EN
    check("add_7fff_1_ovf", 32'(rsp_ovf), 32'd1);
`endif

    // Round-robin from reset with both requesters continuously valid.
    pulse_reset();
    exp_q.delete();
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    req0_A = 16'h0005; req0_B = 16'h0006; req0_cin = 1'b0;
    req1_A = 16'h0100; req1_B = 16'h0200; req1_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 80 && n_rsp < 4; i++) begin
      @(negedge Clk);
      if (rsp_valid && exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("rr_id", 32'(rsp_id), 32'(e));
        check("rr_S",  32'(rsp_S),  (e == 16'd0) ? 32'h000B : 32'h0301);
        n_rsp++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_count", 32'(n_rsp), 32'd4);

    // A lone request still moves the pointer, so the next tie goes to requester 1.
    do_op("lone0", 1'b0, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);
    @(negedge Clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("tie_req0_ready", 32'(req0_ready), 32'd0);
    check("tie_req1_ready", 32'(req1_ready), 32'd1);
    // Withdrawn before any edge: no grant may result.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("drop_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge Clk);
    check("drop_state", 32'(dbg_state), 32'd0);

    // Back-pressure: the response holds while rsp_ready stays low.
    rsp_ready = 1'b0;
    send_req(1'b0, 16'hABCD, 16'h1111, 1'b0);
    wait_rsp();
    req1_A = 16'h0010; req1_B = 16'h0020; req1_cin = 1'b0;
    req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_valid", 32'(rsp_valid),  32'd1);
      check("hold_S",     32'(rsp_S),      32'hBCDE);
      check("hold_cout",  32'(rsp_cout),   32'd0);
      check("hold_id",    32'(rsp_id),     32'd0);
      check("hold_rdy0",  32'(req0_ready), 32'd0);
      check("hold_rdy1",  32'(req1_ready), 32'd0);
      @(negedge Clk);
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    #1;
    check("hold_released", 32'(rsp_valid),  32'd0);
    check("next_grant1",   32'(req1_ready), 32'd1);
    grant_cyc = cyc + 1;
    @(posedge Clk);
    @(negedge Clk);
    req1_valid = 1'b0;
    wait_rsp();
    check("after_hold_lat", 32'(lat),    32'd2);
    check("after_hold_S",   32'(got_s),  32'h0030);
    check("after_hold_id",  32'(got_id), 32'd1);

    // Reset during SETTLE discards the operation.
    send_req(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    check("in_settle", 32'(dbg_state), 32'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_S",     32'(rsp_S),     32'd0);
    check("midrst_cout",  32'(rsp_cout),  32'd0);
    check("midrst_id",    32'(rsp_id),    32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    n_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (rsp_valid) n_bad++;
    end
    check("midrst_no_rsp", 32'(n_bad), 32'd0);
    do_op("post_rst", 1'b0, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0);

    // SETTLE_CYCLES = 4 instance: the response appears 5 cycles after the grant.
    @(negedge Clk);
    s4_req0_A = 16'h1234; s4_req0_B = 16'h4321; s4_req0_cin = 1'b0;
    s4_req0_valid = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (s4_req0_ready) begin
          seen = 1'b1;
          break;
        end
        @(negedge Clk);
      end
      check("s4_grant_seen", 32'(seen), 32'd1);
    end
    grant_cyc = cyc + 1;
    @(posedge Clk);
    @(negedge Clk);
    s4_req0_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (s4_rsp_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge Clk);
      end
      check("s4_rsp_seen", 32'(seen), 32'd1);
    end
    check("s4_lat",  32'(cyc - grant_cyc), 32'd5);
    check("s4_S",    32'(s4_rsp_S),        32'h5555);
    check("s4_cout", 32'(s4_rsp_cout),     32'd0);
    check("s4_id",   32'(s4_rsp_id),       32'd0);

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Overall time bound on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 1, range 1-15: cycles the shared adder is given to settle before its result is captured.
REQ-002 The module SHALL have Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have Reset_n, input, 1: synchronous, active-low reset.
REQ-004 The module SHALL have req0_valid, input, 1, and req0_ready, output, 1: requester 0 handshake.
REQ-005 The module SHALL have req0_A, req0_B, input, 16 each, and req0_cin, input, 1: requester 0 operands.
REQ-006 The module SHALL have req1_valid, input, 1; req1_ready, output, 1; req1_A, req1_B, input, 16; req1_cin, input, 1: requester 1, same meaning.
REQ-007 The module SHALL have rsp_valid, output, 1, and rsp_ready, input, 1: result handshake.
REQ-008 The module SHALL have rsp_S, output, 16; rsp_cout, output, 1; rsp_id, output, 1: sum, carry and serviced requester.

Function
REQ-009 Transfers SHALL occur only on cycles where valid and ready are both high.
REQ-010 FSM states SHALL be IDLE, SETTLE, RESP.
REQ-011 In IDLE, req0_ready and req1_ready SHALL be driven combinationally: only the granted requester sees ready high, and only when its valid is high.
REQ-012 Arbitration SHALL be round-robin: a priority pointer, reset to 0, selects the winner when both valids are high; after each grant it points to the other requester.
REQ-013 When only one valid is high, that requester SHALL win regardless of the pointer, and the pointer SHALL still move to the other requester.
REQ-014 On grant, A, B, cin and id SHALL be registered, the FSM SHALL enter SETTLE, and a settle counter SHALL load SETTLE_CYCLES-1.
REQ-015 In SETTLE, both ready outputs SHALL be low; the counter SHALL decrement each cycle.
REQ-016 When the counter reaches 0, the adder's S and cout SHALL be captured into rsp registers and the FSM SHALL enter RESP on the next cycle.
REQ-017 With SETTLE_CYCLES=1, rsp_valid SHALL rise exactly 2 cycles after the grant edge.
REQ-018 In RESP, rsp_valid SHALL be high and rsp_S, rsp_cout, rsp_id SHALL hold stable until rsp_ready is high.
REQ-019 On the RESP handshake, the FSM SHALL return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-020 Addition SHALL be unsigned 16-bit modulo 2^16, with carry-out on rsp_cout.
REQ-021 Requester valids deasserting while not granted SHALL have no effect.

Reset
REQ-022 While Reset_n is low at a clock edge, the FSM SHALL go to IDLE, the pointer to 0, and the counter to 0.
REQ-023 Reset SHALL clear rsp_valid, rsp_S, rsp_cout and rsp_id to 0; both ready outputs SHALL be 0 during reset.
REQ-024 Reset asserted in SETTLE or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-025 With macro ADDER_ARBITER_OVF_EN defined, an output rsp_ovf, 1 bit, SHALL report signed two's-complement overflow: operand MSBs equal and sum MSB different. It SHALL be registered alongside rsp_S and reset to 0.
REQ-026 Without ADDER_ARBITER_OVF_EN defined, port rsp_ovf and its logic SHALL be absent.

Structure
REQ-027 A shared package adder_arbiter_pkg SHALL hold the FSM state enum and the 16-bit data width constant.
REQ-028 The datapath SHALL be one instance of the team's existing 16-bit ripple adder, fed from the operand registers. No other sub-module SHALL be used.

Verification
REQ-029 Reset, then req0 with A=0x0001, B=0x0002, cin=0, rsp_ready=1 -> rsp_S=0x0003, cout=0, id=0, with rsp_valid 2 cycles after the grant.
REQ-030 Both valid from reset -> grants in the order id 0, 1, 0, 1 over four operations; no requester is granted twice in a row.
REQ-031 A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1. With ADDER_ARBITER_OVF_EN, A=0x7FFF, B=0x0001 -> S=0x8000, ovf=1.
REQ-032 rsp_ready held low 5 cycles -> rsp_valid and data stable for all 5 cycles, and both ready outputs stay low.
REQ-033 Reset_n pulsed low during SETTLE -> no response is produced, all outputs read 0, and the next request completes correctly.
REQ-034 SETTLE_CYCLES=4, A=0x1234, B=0x4321 -> S=0x5555, with rsp_valid 5 cycles after the grant.
